// File: rtl/pio_hex_display.sv
// Shows the PIO output byte as two multiplexed hex digits on a common-anode display.
// Each new value blinks the display a fixed number of times before it stays lit.
module pio_hex_display #(
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_CYCLES = 12500000,
  parameter int BLINK_COUNT  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pio_data,
  input  logic       enable,
  output logic [6:0] seg_n,
  output logic [1:0] dig_n,
  output logic       update_pulse
);

  // state  | meaning
  // SHOW   | value shown steadily
  // BLINK  | new value flagged: even phases blank, odd phases lit
  // OFF    | display blanked by enable=0

  localparam int SCAN_W  = $clog2(CLK_DIV);
  localparam int BLINK_W = $clog2(BLINK_CYCLES);
  localparam int PHASE_W = $clog2(2 * BLINK_COUNT);

  localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(CLK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_TC = PHASE_W'(2 * BLINK_COUNT - 1);

  typedef enum logic [1:0] {ST_SHOW, ST_BLINK, ST_OFF} state_t;

  state_t             state_q, state_d;
  logic [7:0]         shown_q, shown_d;
  logic [SCAN_W-1:0]  scan_q, scan_d;
  logic               sel_q, sel_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [6:0]         seg_n_q, seg_n_d;
  logic [1:0]         dig_n_q, dig_n_d;
  logic               pulse_q, pulse_d;

  logic       change;
  logic       lit;
  logic [3:0] nibble;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SHOW;
      shown_q <= 8'h00;
      scan_q  <= '0;
      sel_q   <= 1'b0;
      blink_q <= '0;
      phase_q <= '0;
      seg_n_q <= 7'h7F;
      dig_n_q <= 2'b11;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      seg_n_q <= seg_n_d;
      dig_n_q <= dig_n_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
    blink_d = blink_q;
    phase_d = phase_q;
    pulse_d = 1'b0;
    change  = (pio_data != shown_q);

    if (change) begin
      shown_d = pio_data;
      pulse_d = 1'b1;
    end

    case (state_q)
      ST_BLINK: begin
        if (blink_q == BLINK_TC) begin
          blink_d = '0;
          if (phase_q == PHASE_TC) begin
            phase_d = '0;
            state_d = ST_SHOW;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end else begin
          blink_d = blink_q + BLINK_W'(1);
        end
      end
      ST_OFF:  state_d = ST_SHOW;
      default: state_d = ST_SHOW;
    endcase

    if (change) begin
      state_d = ST_BLINK;
      blink_d = '0;
      phase_d = '0;
    end

    // enable=0 wins over a change; shown still tracks the input above
    if (!enable) begin
      state_d = ST_OFF;
      blink_d = '0;
      phase_d = '0;
    end
  end

  always_comb begin
    scan_d = (scan_q == SCAN_TC) ? '0 : scan_q + SCAN_W'(1);
    sel_d  = (scan_q == SCAN_TC) ? ~sel_q : sel_q;
  end

  always_comb begin
    lit    = (state_q == ST_SHOW) || ((state_q == ST_BLINK) && phase_q[0]);
    nibble = sel_q ? shown_q[7:4] : shown_q[3:0];
    case (nibble)
      4'h0:    seg_n_d = 7'h40;
      4'h1:    seg_n_d = 7'h79;
      4'h2:    seg_n_d = 7'h24;
      4'h3:    seg_n_d = 7'h30;
      4'h4:    seg_n_d = 7'h19;
      4'h5:    seg_n_d = 7'h12;
      4'h6:    seg_n_d = 7'h02;
      4'h7:    seg_n_d = 7'h78;
      4'h8:    seg_n_d = 7'h00;
      4'h9:    seg_n_d = 7'h10;
      4'hA:    seg_n_d = 7'h08;
      4'hB:    seg_n_d = 7'h03;
      4'hC:    seg_n_d = 7'h46;
      4'hD:    seg_n_d = 7'h21;
      4'hE:    seg_n_d = 7'h06;
      default: seg_n_d = 7'h0E;
    endcase
    dig_n_d = sel_q ? 2'b01 : 2'b10;
    if (!lit) begin
      seg_n_d = 7'h7F;
      dig_n_d = 2'b11;
    end
  end

  assign seg_n        = seg_n_q;
  assign dig_n        = dig_n_q;
  assign update_pulse = pulse_q;

endmodule

// File: tb/tb_pio_hex_display.sv
// Self-checking bench for pio_hex_display: cycle model built from timing arithmetic,
// decode table vectors, and directed blink/enable/reset sequences plus random traffic.
module tb_pio_hex_display;
  localparam int CD  = 4;
  localparam int BCY = 8;
  localparam int BCN = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pio_data;
  logic       enable;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  logic       update_pulse;

  pio_hex_display #(.CLK_DIV(CD), .BLINK_CYCLES(BCY), .BLINK_COUNT(BCN)) dut (
    .clk(clk), .reset_n(reset_n), .pio_data(pio_data), .enable(enable),
    .seg_n(seg_n), .dig_n(dig_n), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses_seen = 0;

  // model: m = clock edges since reset release, blink window measured from mstart
  int         m;
  logic [7:0] mshown;
  bit         moff, mblink;
  int         mstart;
  logic [6:0] cap_lo, cap_hi;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [7:0] val;
    logic [6:0] lo;
    logic [6:0] hi;
  } vec_t;
  vec_t tv [16];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, m, $time);
    end
  endtask

  function automatic bit model_lit();
    if (moff) return 1'b0;
    if (mblink && (m - mstart) < 2 * BCN * BCY) return (((m - mstart) / BCY) % 2) == 1;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m = 0; mshown = 8'h00; moff = 0; mblink = 0; mstart = 0;
  endfunction

  task automatic step();
    bit         e_lit, sel, change;
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    e_lit  = model_lit();
    sel    = ((m / CD) % 2) == 1;
    e_dig  = e_lit ? (sel ? 2'b01 : 2'b10) : 2'b11;
    e_seg  = e_lit ? seg_tab[sel ? mshown[7:4] : mshown[3:0]] : 7'h7F;
    change = (pio_data != mshown);
    if (change) mshown = pio_data;
    if (!enable) begin
      moff = 1; mblink = 0;
    end else if (change) begin
      mblink = 1; mstart = m + 1; moff = 0;
    end else if (moff) begin
      moff = 0;
    end
    m = m + 1;
    @(posedge clk);
    #1;
    chk("seg_n", seg_n, e_seg);
    chk("dig_n", dig_n, e_dig);
    chk("update_pulse", update_pulse, change);
    if (update_pulse) pulses_seen++;
    if (dig_n == 2'b10) cap_lo = seg_n;
    if (dig_n == 2'b01) cap_hi = seg_n;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    tv[0]  = '{8'h0F, 7'h0E, 7'h40};  tv[1]  = '{8'h1E, 7'h06, 7'h79};
    tv[2]  = '{8'h2D, 7'h21, 7'h24};  tv[3]  = '{8'h3C, 7'h46, 7'h30};
    tv[4]  = '{8'h4B, 7'h03, 7'h19};  tv[5]  = '{8'h5A, 7'h08, 7'h12};
    tv[6]  = '{8'h69, 7'h10, 7'h02};  tv[7]  = '{8'h78, 7'h00, 7'h78};
    tv[8]  = '{8'h87, 7'h78, 7'h00};  tv[9]  = '{8'h96, 7'h02, 7'h10};
    tv[10] = '{8'hA5, 7'h12, 7'h08};  tv[11] = '{8'hB4, 7'h19, 7'h03};
    tv[12] = '{8'hC3, 7'h30, 7'h46};  tv[13] = '{8'hD2, 7'h24, 7'h21};
    tv[14] = '{8'hE1, 7'h79, 7'h06};  tv[15] = '{8'hF0, 7'h40, 7'h0E};

    // reset with data 00
    reset_n = 1'b0; pio_data = 8'h00; enable = 1'b1;
    model_reset();
    #12;
    chk("rst_seg_n", seg_n, 7'h7F);
    chk("rst_dig_n", dig_n, 2'b11);
    chk("rst_pulse", update_pulse, 0);
    @(negedge clk); reset_n = 1'b1;
    run(40);
    chk("no_pulse_after_reset", pulses_seen, 0);

    // 00 -> A5, full blink then steady
    pulses_seen = 0;
    pio_data = 8'hA5; run(48);
    chk("a5_pulse_count", pulses_seen, 1);
    chk("a5_lo_digit", cap_lo, 7'h12);
    chk("a5_hi_digit", cap_hi, 7'h08);

    // second change during the third blink phase restarts the blink
    pulses_seen = 0;
    pio_data = 8'h11; run(19);
    pio_data = 8'h3C; run(48);
    chk("restart_pulse_count", pulses_seen, 2);
    chk("3c_lo_digit", cap_lo, 7'h46);
    chk("3c_hi_digit", cap_hi, 7'h30);

    // enable=0 mid-blink, change while OFF, re-enable without blink
    pulses_seen = 0;
    pio_data = 8'h5A; run(11);
    enable = 1'b0; run(5);
    pio_data = 8'hFF; run(6);
    enable = 1'b1; run(12);
    chk("off_pulse_count", pulses_seen, 2);
    chk("ff_lo_digit", cap_lo, 7'h0E);
    chk("ff_hi_digit", cap_hi, 7'h0E);

    // decode vectors, loaded through OFF so they show without blinking
    for (int i = 0; i < 16; i++) begin
      enable = 1'b0; step();
      pio_data = tv[i].val; step();
      enable = 1'b1;
      cap_lo = 7'h7F; cap_hi = 7'h7F;
      run(10);
      chk($sformatf("dec_lo_%02h", tv[i].val), cap_lo, tv[i].lo);
      chk($sformatf("dec_hi_%02h", tv[i].val), cap_hi, tv[i].hi);
    end

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(39) == 0) pio_data = 8'($urandom);
      if ($urandom_range(59) == 0) enable = ~enable;
      step();
    end
    enable = 1'b1; run(40);

    // async reset mid-blink
    pio_data = 8'h77; run(6);
    #3 reset_n = 1'b0;
    #1;
    chk("async_seg_n", seg_n, 7'h7F);
    chk("async_dig_n", dig_n, 2'b11);
    chk("async_pulse", update_pulse, 0);
    pio_data = 8'h00;
    @(posedge clk); #1;
    chk("hold_rst_dig_n", dig_n, 2'b11);
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    pulses_seen = 0;
    run(20);
    chk("post_reset_pulses", pulses_seen, 0);
    chk("post_reset_lo", cap_lo, 7'h40);

    // long stable hold
    pio_data = 8'h96; run(40);
    pulses_seen = 0;
    run(1000);
    chk("stable_no_pulse", pulses_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1);
  end

endmodule
